// File: rtl/tftlcd_rx.sv
// tftlcd_rx: DE-mode TFT panel-bus receiver recovering pixel X/Y, SOF/EOF and sticky timing errors.
// Define TFTLCD_RX_CHECKSUM_EN to enable the per-frame pixel checksum on o_FrameSum.
module tftlcd_rx #(
  parameter int X_PX            = 800,
  parameter int Y_PX            = 480,
  parameter int DATA_WIDTH      = 24,
  parameter int X_COUNTER_WIDTH = 10,
  parameter int Y_COUNTER_WIDTH = 9,
  parameter int V_GAP_MIN       = 2000
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic [DATA_WIDTH-1:0]      RGB,
  input  logic                       DEN,
  input  logic                       STBYB,
  output logic                       o_Valid,
  output logic [DATA_WIDTH-1:0]      o_RGB,
  output logic [X_COUNTER_WIDTH-1:0] o_XPx,
  output logic [Y_COUNTER_WIDTH-1:0] o_YPx,
  output logic                       o_SOF,
  output logic                       o_EOF,
  output logic                       o_Locked,
  output logic                       o_LineErr,
  output logic                       o_FrameErr,
  output logic [DATA_WIDTH-1:0]      o_FrameSum
);

  localparam int GAP_W = $clog2(V_GAP_MIN + 1);
  localparam logic [GAP_W-1:0]           GAP_MAX = GAP_W'(V_GAP_MIN);
  localparam logic [GAP_W-1:0]           GAP_HIT = GAP_W'(V_GAP_MIN - 1);
  localparam logic [X_COUNTER_WIDTH-1:0] X_FULL  = X_COUNTER_WIDTH'(X_PX);
  localparam logic [X_COUNTER_WIDTH-1:0] X_LAST  = X_COUNTER_WIDTH'(X_PX - 1);
  localparam logic [Y_COUNTER_WIDTH-1:0] Y_FULL  = Y_COUNTER_WIDTH'(Y_PX);
  localparam logic [Y_COUNTER_WIDTH-1:0] Y_LAST  = Y_COUNTER_WIDTH'(Y_PX - 1);

  typedef enum logic [1:0] {IDLE, SEEK, ACTIVE} state_e;

  state_e                     state_q, state_d;
  logic [DATA_WIDTH-1:0]      rgb_s_q;
  logic                       den_s_q, stbyb_s_q;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [X_COUNTER_WIDTH-1:0] col_q, col_d;
  logic [Y_COUNTER_WIDTH-1:0] row_q, row_d;
  logic                       valid_q, valid_d;
  logic [DATA_WIDTH-1:0]      rgb_o_q, rgb_o_d;
  logic [X_COUNTER_WIDTH-1:0] x_o_q, x_o_d;
  logic [Y_COUNTER_WIDTH-1:0] y_o_q, y_o_d;
  logic                       sof_q, sof_d, eof_q, eof_d;
  logic                       lerr_q, lerr_d, ferr_q, ferr_d;
  logic                       emit;
  logic [X_COUNTER_WIDTH-1:0] emit_x;
  logic [Y_COUNTER_WIDTH-1:0] emit_y;
  logic                       rising, gap_full, gap_hit;

  // gap_q counts DEN-low samples up to the previous one, so nonzero with DEN high is a rising edge
  assign rising   = den_s_q && (gap_q != '0);
  assign gap_full = (gap_q == GAP_MAX);
  assign gap_hit  = !den_s_q && (gap_q == GAP_HIT);

  always_comb begin
    gap_d = den_s_q ? '0 : (gap_full ? gap_q : gap_q + 1'b1);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    rgb_o_d = rgb_o_q;
    x_o_d   = x_o_q;
    y_o_d   = y_o_q;
    lerr_d  = lerr_q;
    ferr_d  = ferr_q;
    emit    = 1'b0;
    emit_x  = col_q;
    emit_y  = row_q;
    if (!stbyb_s_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          if (rising && gap_full) begin
            state_d = ACTIVE;
            row_d   = '0;
            emit    = 1'b1;
            emit_x  = '0;
            emit_y  = '0;
          end
        end
        ACTIVE: begin
          if (den_s_q) begin
            if (rising) begin
              if (gap_full) begin
                row_d  = '0;
                emit   = 1'b1;
                emit_x = '0;
                emit_y = '0;
              end else if (row_q == Y_FULL) begin
                ferr_d  = 1'b1;
                state_d = SEEK;
              end else begin
                emit   = 1'b1;
                emit_x = '0;
              end
            end else if (col_q == X_FULL) begin
              lerr_d  = 1'b1;
              state_d = SEEK;
            end else begin
              emit = 1'b1;
            end
          end else if (gap_q == '0) begin
            if (col_q != X_FULL) begin
              lerr_d  = 1'b1;
              state_d = SEEK;
            end else begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end
          end else if (gap_hit && row_q != '0 && row_q != Y_FULL) begin
            ferr_d  = 1'b1;
            state_d = SEEK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (emit) begin
      valid_d = 1'b1;
      rgb_o_d = rgb_s_q;
      x_o_d   = emit_x;
      y_o_d   = emit_y;
      sof_d   = (emit_x == '0) && (emit_y == '0);
      eof_d   = (emit_x == X_LAST) && (emit_y == Y_LAST);
      col_d   = emit_x + 1'b1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rgb_s_q   <= '0;
      den_s_q   <= 1'b0;
      stbyb_s_q <= 1'b0;
      state_q   <= IDLE;
      gap_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      valid_q   <= 1'b0;
      rgb_o_q   <= '0;
      x_o_q     <= '0;
      y_o_q     <= '0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      lerr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rgb_s_q   <= RGB;
      den_s_q   <= DEN;
      stbyb_s_q <= STBYB;
      state_q   <= state_d;
      gap_q     <= gap_d;
      col_q     <= col_d;
      row_q     <= row_d;
      valid_q   <= valid_d;
      rgb_o_q   <= rgb_o_d;
      x_o_q     <= x_o_d;
      y_o_q     <= y_o_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      lerr_q    <= lerr_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef TFTLCD_RX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;

  // acc_q already holds the EOF pixel when o_EOF is high, so the sum is published a cycle later
  always_comb begin
    acc_d = acc_q;
    if (emit) acc_d = sof_d ? rgb_s_q : acc_q + rgb_s_q;
    sum_d = eof_q ? acc_q : sum_q;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign o_FrameSum = sum_q;
`else
  assign o_FrameSum = '0;
`endif

  assign o_Valid    = valid_q;
  assign o_RGB      = rgb_o_q;
  assign o_XPx      = x_o_q;
  assign o_YPx      = y_o_q;
  assign o_SOF      = sof_q;
  assign o_EOF      = eof_q;
  assign o_Locked   = (state_q == ACTIVE);
  assign o_LineErr  = lerr_q;
  assign o_FrameErr = ferr_q;

endmodule

// File: tb/tb_tftlcd_rx.sv
// Bench for tftlcd_rx: a small panel generator drives frames whose expected pixel stream
// is derived from the generator's own coordinates and the scenario it is asked to produce.
module tb_tftlcd_rx;
  localparam int XP = 8;
  localparam int YP = 4;
  localparam int DW = 24;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int VG = 20;
  localparam int HB = 5;
  localparam int VB = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rgb = '0;
  logic          den = 1'b0;
  logic          stb = 1'b1;

  logic          o_Valid, o_SOF, o_EOF, o_Locked, o_LineErr, o_FrameErr;
  logic [DW-1:0] o_RGB, o_FrameSum;
  logic [XW-1:0] o_XPx;
  logic [YW-1:0] o_YPx;

  tftlcd_rx #(
    .X_PX(XP), .Y_PX(YP), .DATA_WIDTH(DW),
    .X_COUNTER_WIDTH(XW), .Y_COUNTER_WIDTH(YW), .V_GAP_MIN(VG)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .RGB(rgb), .DEN(den), .STBYB(stb),
    .o_Valid(o_Valid), .o_RGB(o_RGB), .o_XPx(o_XPx), .o_YPx(o_YPx),
    .o_SOF(o_SOF), .o_EOF(o_EOF), .o_Locked(o_Locked),
    .o_LineErr(o_LineErr), .o_FrameErr(o_FrameErr), .o_FrameSum(o_FrameSum)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            valid;
    int            x;
    int            y;
    bit            sof;
    bit            eof;
    logic [DW-1:0] rgb;
    bit            lock;
    bit            lerr;
    bit            ferr;
    logic [DW-1:0] fsum;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  bit            m_on = 1'b0;
  int            run = 0;
  int            lines_done = 0;
  bit            e_lerr = 1'b0;
  bit            e_ferr = 1'b0;
  logic [DW-1:0] e_fsum = '0;
  logic [DW-1:0] acc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit v, input int x, input int y, input logic [DW-1:0] r);
    exp_t e;
    e.valid = v; e.x = x; e.y = y; e.sof = 1'b0; e.eof = 1'b0; e.rgb = r;
    e.lock = m_on; e.lerr = e_lerr; e.ferr = e_ferr; e.fsum = e_fsum;
    return e;
  endfunction

  task automatic check_front();
    exp_t e;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("valid", o_Valid, e.valid);
      chk("sof", o_SOF, e.sof);
      chk("eof", o_EOF, e.eof);
      chk("locked", o_Locked, e.lock);
      chk("line_err", o_LineErr, e.lerr);
      chk("frame_err", o_FrameErr, e.ferr);
      chk("frame_sum", o_FrameSum, e.fsum);
      if (e.valid) begin
        chk("xpx", o_XPx, e.x);
        chk("ypx", o_YPx, e.y);
        chk("rgb", o_RGB, e.rgb);
      end
    end
  endtask

  task automatic cyc(input bit d, input logic [DW-1:0] r, input bit s, input exp_t e);
    @(negedge clk);
    check_front();
    den = d; rgb = r; stb = s;
    q.push_back(e);
  endtask

  task automatic low(input int n, input bit s);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      run++;
      if (m_on && run == VG && lines_done >= 1 && lines_done < YP) begin
        e_ferr = 1'b1; m_on = 1'b0;
      end
      e = mk(1'b0, 0, 0, '0);
      cyc(1'b0, DW'($urandom()), s, e);
    end
  endtask

  task automatic frame(input int nl, input int bad_row, input int bad_len, input int sb_row,
                       input int sb_col, input int vb, input bit const1, input int cut);
    exp_t          e;
    bit            sb;
    int            len;
    int            cnt;
    logic [DW-1:0] px;
    cnt = 0;
    if (run >= VG) m_on = 1'b1;
    else if (m_on) begin e_ferr = 1'b1; m_on = 1'b0; end
    acc = '0;
    lines_done = 0;
    for (int y = 0; y < nl; y++) begin
      len = (y == bad_row) ? bad_len : XP;
      if (y == YP && m_on) begin e_ferr = 1'b1; m_on = 1'b0; end
      for (int x = 0; x < len; x++) begin
        sb = !(sb_row >= 0 && (y > sb_row || (y == sb_row && x >= sb_col)));
        px = const1 ? DW'(1) : DW'($urandom());
        if (!sb) m_on = 1'b0;
        if (m_on && x == XP) begin e_lerr = 1'b1; m_on = 1'b0; end
        if (m_on) begin
          acc = acc + px;
          e = mk(1'b1, x, y, px);
          e.sof = (x == 0 && y == 0);
          e.eof = (x == XP - 1 && y == YP - 1);
        end else begin
          e = mk(1'b0, 0, 0, '0);
        end
        cyc(1'b1, px, sb, e);
`ifdef TFTLCD_RX_CHECKSUM_EN
        if (e.eof) e_fsum = acc;
`endif
        cnt++;
        if (cut >= 0 && cnt == cut) return;
      end
      run = 0;
      if (m_on && len < XP) begin e_lerr = 1'b1; m_on = 1'b0; end
      lines_done = y + 1;
      if (y < nl - 1) low(HB, !(sb_row >= 0 && y >= sb_row));
    end
    low(vb, 1'b1);
  endtask

  task automatic good(input int vb);
    frame(YP, -1, 0, -1, 0, vb, 1'b0, -1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", o_Valid, 0);
    chk("rst_locked", o_Locked, 0);
    chk("rst_line_err", o_LineErr, 0);
    chk("rst_frame_err", o_FrameErr, 0);
    chk("rst_sof", o_SOF, 0);
    chk("rst_eof", o_EOF, 0);
    chk("rst_xpx", o_XPx, 0);
    chk("rst_ypx", o_YPx, 0);
    chk("rst_rgb", o_RGB, 0);
    chk("rst_frame_sum", o_FrameSum, 0);
    repeat (2) @(negedge clk);
    den = 1'b0; stb = 1'b1;
    rst = 1'b0;
    q.delete();
    m_on = 1'b0; run = 0; lines_done = 0;
    e_lerr = 1'b0; e_ferr = 1'b0; e_fsum = '0;
  endtask

  initial begin
    #12;
    chk("init_valid", o_Valid, 0);
    chk("init_locked", o_Locked, 0);
    chk("init_line_err", o_LineErr, 0);
    chk("init_frame_err", o_FrameErr, 0);
    chk("init_frame_sum", o_FrameSum, 0);
    @(negedge clk);
    rst = 1'b0;

    // first frame has no preceding vertical gap and is discarded
    good(VB);
    good(VB);
    frame(YP, -1, 0, -1, 0, VB, 1'b1, -1);
`ifdef TFTLCD_RX_CHECKSUM_EN
    chk("frame_sum_const", o_FrameSum, XP * YP);
`else
    chk("frame_sum_const", o_FrameSum, 0);
`endif

    // over-long line, then relock
    frame(YP, 1, XP + 1, -1, 0, VB, 1'b0, -1);
    good(VB);
    chk("line_err_sticky", o_LineErr, 1);

    // reset in the middle of a line clears sticky flags
    frame(YP, -1, 0, -1, 0, VB, 1'b0, XP + 3);
    async_reset();
    good(VB);
    good(VB);

    // short line
    frame(YP, 2, XP - 3, -1, 0, VB, 1'b0, -1);
    good(VB);

    // frame one line short, then one line long
    async_reset();
    good(VB);
    good(VB);
    frame(YP - 1, -1, 0, -1, 0, VB, 1'b0, -1);
    good(VB);
    async_reset();
    good(VB);
    good(VB);
    frame(YP + 1, -1, 0, -1, 0, VB, 1'b0, -1);
    good(VB);

    // standby mid-frame, then relock
    async_reset();
    good(VB);
    good(VB);
    frame(YP, -1, 0, YP / 2, XP / 2, VB, 1'b0, -1);
    good(VB);

    // vertical gap one short of the minimum, locked and unlocked, then exactly the minimum
    good(VG - 1);
    good(VG - 1);
    good(VG);
    good(VB);
    low(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
